// File: rtl/cv32e41s_write_buffer_fifo.sv
// Multi-entry OBI data write buffer: absorbs bufferable stores while the bus stalls, strict in-order.
// Optional stall-cycle counter enabled by defining CV32E41S_WBUF_STALL_CNT_EN.

package cv32e41s_write_buffer_fifo_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        integrity;
  } pma_cfg_t;

  localparam pma_cfg_t PMA_R_DEFAULT = '{word_addr_low: 32'h0, word_addr_high: 32'h0,
                                         main: 1'b0, bufferable: 1'b0, cacheable: 1'b0,
                                         integrity: 1'b0};

endpackage

module cv32e41s_write_buffer_fifo
  import cv32e41s_write_buffer_fifo_pkg::*;
#(
  parameter int unsigned DEPTH           = 2,
  parameter int          PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t    PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  obi_data_req_t                trans_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output obi_data_req_t                trans_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic [15:0]                  stall_cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;

  obi_data_req_t       mem_q [DEPTH];
  ptr_t                rd_ptr_q, rd_ptr_d;
  ptr_t                wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                empty;
  logic                bufferable;
  logic                push;
  logic                pop;

  // PMA parameters are carried only for configuration consistency.
  logic unused_pma;
  assign unused_pma = PMA_CFG[0].main ^ (PMA_NUM_REGIONS == 0);

  function automatic ptr_t ptr_incr(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign empty      = (count_q == '0);
  assign bufferable = trans_i.memtype[0];

  always_comb begin
    valid_o = valid_i;
    trans_o = trans_i;
    ready_o = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (empty) begin
      ready_o = bufferable | ready_i;
      push    = valid_i & bufferable & ~ready_i;
    end else begin
      valid_o = 1'b1;
      trans_o = mem_q[rd_ptr_q];
      pop     = ready_i;
      ready_o = bufferable & ((count_q < CntW'(DEPTH)) | ready_i);
      push    = valid_i & ready_o;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = ptr_incr(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_incr(rd_ptr_q);
    if (push && !pop) count_d = count_q + CntW'(1);
    if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i]    <= '0;
        mem_q[i].we <= 1'b1;
      end
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) mem_q[wr_ptr_q] <= trans_i;
    end
  end

  assign count_o = count_q;
  assign empty_o = empty;

`ifdef CV32E41S_WBUF_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (valid_i && !ready_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CntW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count_q == '0)));
`endif

endmodule

// File: tb/tb_cv32e41s_write_buffer_fifo.sv
// Directed bench for the write buffer FIFO: DEPTH=2 vector table plus DEPTH=3 wrap and reset sequences.

module tb_cv32e41s_write_buffer_fifo;
  import cv32e41s_write_buffer_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          v2, r2, vo2, ro2, emp2;
  obi_data_req_t t2, to2;
  logic [1:0]    cnt2;
  logic [15:0]   sc2;

  logic          v3, r3, vo3, ro3, emp3;
  obi_data_req_t t3, to3;
  logic [1:0]    cnt3;
  logic [15:0]   sc3;

  cv32e41s_write_buffer_fifo #(.DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .valid_i(v2), .trans_i(t2), .ready_o(ro2), .valid_o(vo2),
    .trans_o(to2), .ready_i(r2), .count_o(cnt2), .empty_o(emp2), .stall_cnt_o(sc2)
  );

  cv32e41s_write_buffer_fifo #(.DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .valid_i(v3), .trans_i(t3), .ready_o(ro3), .valid_o(vo3),
    .trans_o(to3), .ready_i(r3), .count_o(cnt3), .empty_o(emp3), .stall_cnt_o(sc3)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obi_data_req_t mk(input logic [31:0] a, input logic b);
    obi_data_req_t t;
    t         = '0;
    t.addr    = a;
    t.we      = 1'b1;
    t.be      = 4'hF;
    t.wdata   = ~a;
    t.memtype = {1'b0, b};
    return t;
  endfunction

  typedef struct {
    logic        v;
    logic        b;
    logic [31:0] a;
    logic        r;
    logic        ev;
    logic        er;
    logic [31:0] ea;
    logic        eb;
    int          ec;
  } vec_t;

  vec_t tbl[17];
  obi_data_req_t rv;
  logic [31:0] exp3_a[3];
  int exp3_c[3];

  initial begin
    rv    = '0;
    rv.we = 1'b1;
    //          v     b     a         r      ev    er    ea        eb   ec
    tbl[0]  = '{1'b0, 1'b1, 32'h0,    1'b0,  1'b0, 1'b1, 32'h0,    1'b1, 0};
    tbl[1]  = '{1'b1, 1'b1, 32'h100,  1'b1,  1'b1, 1'b1, 32'h100,  1'b1, 0};
    tbl[2]  = '{1'b1, 1'b1, 32'h200,  1'b0,  1'b1, 1'b1, 32'h200,  1'b1, 0};
    tbl[3]  = '{1'b1, 1'b1, 32'h204,  1'b0,  1'b1, 1'b1, 32'h200,  1'b1, 1};
    tbl[4]  = '{1'b1, 1'b1, 32'h208,  1'b0,  1'b1, 1'b0, 32'h200,  1'b1, 2};
    tbl[5]  = '{1'b1, 1'b1, 32'h208,  1'b1,  1'b1, 1'b1, 32'h200,  1'b1, 2};
    tbl[6]  = '{1'b0, 1'b1, 32'h0,    1'b1,  1'b1, 1'b1, 32'h204,  1'b1, 2};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,    1'b1,  1'b1, 1'b1, 32'h208,  1'b1, 1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,    1'b1,  1'b0, 1'b1, 32'h0,    1'b1, 0};
    tbl[9]  = '{1'b1, 1'b1, 32'h300,  1'b0,  1'b1, 1'b1, 32'h300,  1'b1, 0};
    tbl[10] = '{1'b1, 1'b1, 32'h304,  1'b0,  1'b1, 1'b1, 32'h300,  1'b1, 1};
    tbl[11] = '{1'b1, 1'b0, 32'h400,  1'b0,  1'b1, 1'b0, 32'h300,  1'b1, 2};
    tbl[12] = '{1'b1, 1'b0, 32'h400,  1'b1,  1'b1, 1'b0, 32'h300,  1'b1, 2};
    tbl[13] = '{1'b1, 1'b0, 32'h400,  1'b1,  1'b1, 1'b0, 32'h304,  1'b1, 1};
    tbl[14] = '{1'b1, 1'b0, 32'h400,  1'b1,  1'b1, 1'b1, 32'h400,  1'b0, 0};
    tbl[15] = '{1'b1, 1'b0, 32'h400,  1'b0,  1'b1, 1'b0, 32'h400,  1'b0, 0};
    tbl[16] = '{1'b0, 1'b1, 32'h0,    1'b0,  1'b0, 1'b1, 32'h0,    1'b1, 0};

    v2 = 1'b0; r2 = 1'b0; t2 = mk(32'h0, 1'b1);
    v3 = 1'b0; r3 = 1'b0; t3 = mk(32'h0, 1'b1);

    // Reset state while held in reset.
    repeat (2) @(negedge clk);
    v2 = 1'b1;
    #1;
    chk("rst_count", 128'(cnt2), 128'(0));
    chk("rst_empty", 128'(emp2), 128'(1));
    chk("rst_valid_passthru", 128'(vo2), 128'(1));
    chk("rst_trans_passthru", 128'(to2), 128'(mk(32'h0, 1'b1)));
    chk("rst_mem0", 128'(u2.mem_q[0]), 128'(rv));
    chk("rst_stall_cnt", 128'(sc2), 128'(0));
    v2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // DEPTH=2 table: pass-through, fill/stall/drain, non-bufferable ordering.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      v2 = tbl[i].v;
      t2 = mk(tbl[i].a, tbl[i].b);
      r2 = tbl[i].r;
      #1;
      chk($sformatf("v%0d_valid_o", i), 128'(vo2), 128'(tbl[i].ev));
      chk($sformatf("v%0d_ready_o", i), 128'(ro2), 128'(tbl[i].er));
      chk($sformatf("v%0d_trans_o", i), 128'(to2), 128'(mk(tbl[i].ea, tbl[i].eb)));
      chk($sformatf("v%0d_count_o", i), 128'(cnt2), 128'(tbl[i].ec));
      chk($sformatf("v%0d_empty_o", i), 128'(emp2), 128'(tbl[i].ec == 0));
    end

    // Stalled cycles in the table: vectors 4, 11, 12, 13 and 15.
`ifdef CV32E41S_WBUF_STALL_CNT_EN
    chk("stall_cnt_5", 128'(sc2), 128'(5));
`else
    chk("stall_cnt_tied", 128'(sc2), 128'(0));
`endif

    // DEPTH=3: fill, push-with-pop at full (write pointer wrapped to 0), drain in order.
    @(negedge clk);
    v3 = 1'b1; r3 = 1'b0; t3 = mk(32'h500, 1'b1);
    #1;
    chk("d3_fill0_count", 128'(cnt3), 128'(0));
    chk("d3_fill0_ready", 128'(ro3), 128'(1));
    @(negedge clk);
    t3 = mk(32'h504, 1'b1);
    #1;
    chk("d3_fill1_count", 128'(cnt3), 128'(1));
    @(negedge clk);
    t3 = mk(32'h508, 1'b1);
    #1;
    chk("d3_fill2_count", 128'(cnt3), 128'(2));
    chk("d3_fill2_ready", 128'(ro3), 128'(1));
    @(negedge clk);
    t3 = mk(32'h50C, 1'b1);
    r3 = 1'b1;
    #1;
    chk("d3_full_count", 128'(cnt3), 128'(3));
    chk("d3_full_ready", 128'(ro3), 128'(1));
    chk("d3_full_head", 128'(to3), 128'(mk(32'h500, 1'b1)));
    exp3_a[0] = 32'h504; exp3_a[1] = 32'h508; exp3_a[2] = 32'h50C;
    exp3_c[0] = 3;       exp3_c[1] = 2;       exp3_c[2] = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v3 = 1'b0;
      #1;
      chk($sformatf("d3_drain%0d_trans", i), 128'(to3), 128'(mk(exp3_a[i], 1'b1)));
      chk($sformatf("d3_drain%0d_count", i), 128'(cnt3), 128'(exp3_c[i]));
      chk($sformatf("d3_drain%0d_valid", i), 128'(vo3), 128'(1));
    end
    @(negedge clk);
    #1;
    chk("d3_empty_count", 128'(cnt3), 128'(0));
    chk("d3_empty_valid", 128'(vo3), 128'(0));
    r3 = 1'b0;

    // Asynchronous reset with two entries buffered.
    @(negedge clk);
    v2 = 1'b1; r2 = 1'b0; t2 = mk(32'h600, 1'b1);
    @(negedge clk);
    t2 = mk(32'h604, 1'b1);
    @(negedge clk);
    v2 = 1'b0;
    #1;
    chk("pre_rst_count", 128'(cnt2), 128'(2));
    chk("pre_rst_head", 128'(to2), 128'(mk(32'h600, 1'b1)));
    #1;
    rst_n = 1'b0;
    v2 = 1'b1;
    t2 = mk(32'h700, 1'b1);
    #1;
    chk("arst_count", 128'(cnt2), 128'(0));
    chk("arst_empty", 128'(emp2), 128'(1));
    chk("arst_valid", 128'(vo2), 128'(1));
    chk("arst_trans", 128'(to2), 128'(mk(32'h700, 1'b1)));
    chk("arst_mem0", 128'(u2.mem_q[0]), 128'(rv));
    chk("arst_mem1", 128'(u2.mem_q[1]), 128'(rv));
    @(negedge clk);
    v2 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_valid", 128'(vo2), 128'(0));
    chk("post_rst_count", 128'(cnt2), 128'(0));

`ifdef CV32E41S_WBUF_STALL_CNT_EN
    chk("stall_cnt_cleared", 128'(sc2), 128'(0));
    // Non-bufferable with no grant stalls every cycle; counter must saturate.
    v2 = 1'b1; r2 = 1'b0; t2 = mk(32'h800, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("stall_cnt_5_nb", 128'(sc2), 128'(5));
    repeat (65540) @(negedge clk);
    #1;
    chk("stall_cnt_sat", 128'(sc2), 128'(16'hFFFF));
    repeat (3) @(negedge clk);
    #1;
    chk("stall_cnt_hold", 128'(sc2), 128'(16'hFFFF));
    v2 = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e41s_write_buffer_fifo.md
Name: cv32e41s_write_buffer_fifo

Overview:
- Parametrised multi-entry successor to the single-word OBI data write buffer. Sits between the load-store unit and the OBI data interface.
- Absorbs up to DEPTH bufferable transfers (memtype[0]=1) while the bus stalls, with zero-latency pass-through when empty.
- Enforces strict in-order issue: a non-bufferable transfer waits until every buffered entry has drained.

Parameters:
- DEPTH, 2, number of buffer entries; legal range 1..8. DEPTH=1 must be cycle-identical to the existing single-word buffer.
- PMA_NUM_REGIONS, 0, passed through for PMA configuration consistency; unused internally.
- PMA_CFG, '{default:PMA_R_DEFAULT}, PMA region table; unused internally.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- valid_i  input  1  upstream transfer valid
- trans_i  input  obi_data_req_t  upstream transfer; memtype[0] = bufferable
- ready_o  output  1  upstream accept
- valid_o  output  1  downstream request valid
- trans_o  output  obi_data_req_t  downstream transfer
- ready_i  input  1  downstream grant
- count_o  output  $clog2(DEPTH+1)  number of occupied entries
- empty_o  output  1  count_o==0
- stall_cnt_o  output  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Storage is a circular FIFO with rd_ptr/wr_ptr in 0..DEPTH-1. Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two. count tracks occupancy.
- Reset state: count=0, both pointers 0, all entries = {we:1, others 0}, stall_cnt=0.
- After reset, outputs follow the combinational rules below: valid_o=valid_i, trans_o=trans_i, empty_o=1, count_o=0.
- Define bufferable = trans_i.memtype[0].
- Empty (count==0):
  - valid_o=valid_i and trans_o=trans_i (pass-through, 0-cycle latency).
  - ready_o = bufferable | ready_i.
  - Push when valid_i & bufferable & !ready_i.
- Non-empty (count>0):
  - valid_o=1 and trans_o=entry[rd_ptr].
  - Pop when ready_i.
  - ready_o = bufferable & (count<DEPTH | ready_i).
  - Push when valid_i & ready_o.
  - A non-bufferable input gets ready_o=0 until count returns to 0. It is then issued through the pass-through path on the first empty cycle with ready_i.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full with a pop, the write lands in the freed slot; there is no overwrite of the head.
- Count updates: push only → count+1; pop only → count−1. Push must never occur at count==DEPTH without a pop, and pop never at count==0 (assert).
- When empty and bufferable with ready_i=1, the transfer passes through without a push.
- Ordering: output order equals acceptance order for all transfers.
- Asserting rst_n mid-operation discards all entries immediately (asynchronous). valid_o falls to valid_i in the same cycle. No partial transfer is retained.

Optional Feature:
- Macro: CV32E41S_WBUF_STALL_CNT_EN.
- When defined: stall_cnt_o is a 16-bit counter that increments every cycle with valid_i & !ready_o, saturates at 16'hFFFF, and is cleared only by reset.
- When undefined: stall_cnt_o is tied to 16'h0000 and no counter flops exist.

Test Plan:
- DEPTH=2, empty, bufferable write A with ready_i=1 → trans_o=A the same cycle, ready_o=1, count_o stays 0.
- DEPTH=2, ready_i=0, bufferable A, B, C on consecutive cycles → A and B accepted (count_o 1→2), C sees ready_o=0. Then ready_i=1 → A, B, C appear on trans_o in order.
- DEPTH=3, count=3, ready_i=1 with bufferable D valid → ready_o=1, count_o stays 3, and D is output 3 pops later. Exercises pointer wrap 2→0.
- count=2, non-bufferable N valid → ready_o=0 for 2 grant cycles. N passes through on the cycle count_o=0 with ready_i=1. Buffered entries always precede N.
- count=2, assert rst_n=0 asynchronously mid-cycle → count_o=0, empty_o=1, valid_o=valid_i immediately. Entries read back as {we:1, 0}.
- With CV32E41S_WBUF_STALL_CNT_EN, hold a non-bufferable input stalled for 5 cycles → stall_cnt_o=5. Forced to 16'hFFFF, it stays at 16'hFFFF on further stalls.
